// File: rtl/ltpi_gpio_pattern_checker.sv
// Checks tunnelled toggle-pattern GPIOs for expected high/low durations; reports lock, sticky errors, error count.
// Optional first-error capture outputs (cap_valid/cap_ch/cap_meas) are enabled by defining LTPI_GPIO_CHK_CAPTURE_EN.
module ltpi_gpio_pattern_checker #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 24,
  parameter int EXP_HIGH = 4750000,
  parameter int EXP_LOW  = 250001,
  parameter int TOL      = 64,
  parameter int LOCK_N   = 2
) (
  input  logic              clk_60m,
  input  logic              rst_n,
  input  logic              aligned,
  input  logic              nl_gpio_stable,
  input  logic [NUM_CH-1:0] mon_in,
  input  logic              clear_err,
  output logic [NUM_CH-1:0] ch_locked,
  output logic              all_locked,
  output logic [NUM_CH-1:0] err_ch,
  output logic [15:0]       err_cnt
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  ,
  output logic                                         cap_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cap_ch,
  output logic [CNT_W-1:0]                             cap_meas
`endif
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [GOOD_W-1:0]   GOOD_MAX = GOOD_W'(LOCK_N);
  localparam logic [CNT_W-1:0]    EXP_H_C  = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]    EXP_L_C  = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0]    LIM_H    = CNT_W'(EXP_HIGH + TOL + 1);
  localparam logic [CNT_W-1:0]    LIM_L    = CNT_W'(EXP_LOW + TOL + 1);
  localparam logic signed [CNT_W:0] TOL_S  = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_TRACK
  } ch_state_t;

  logic [NUM_CH-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] err_ev;
  logic [NUM_CH-1:0] locked_vec;
  logic [NUM_CH-1:0] err_ch_reg;
  logic [15:0]       err_cnt_reg, err_cnt_next;
  logic [16:0]       err_sum;
  logic              all_locked_reg;
  logic              run;

`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  logic [CNT_W-1:0] meas [NUM_CH];
`endif

  assign run = aligned & nl_gpio_stable;

  // Two-stage synchroniser followed by a history register for edge detection.
  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= mon_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign edge_det = sync2_reg ^ prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t                state_reg, state_next;
      logic [CNT_W-1:0]         cnt_reg, cnt_next;
      logic [GOOD_W-1:0]        good_reg, good_next;
      logic                     locked_reg;
      logic                     err_next;
      logic [CNT_W-1:0]         exp_dur, lim;
      logic signed [CNT_W:0]    diff, diff_abs;
      logic                     pass;

      // prev_reg holds the level that was just measured (before the edge).
      assign exp_dur  = prev_reg[gi] ? EXP_H_C : EXP_L_C;
      assign lim      = prev_reg[gi] ? LIM_H : LIM_L;
      assign diff     = $signed({1'b0, cnt_reg}) - $signed({1'b0, exp_dur});
      assign diff_abs = (diff < 0) ? -diff : diff;
      assign pass     = (diff_abs <= TOL_S);

      always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= ST_IDLE;
          cnt_reg    <= '0;
          good_reg   <= '0;
          locked_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          good_reg   <= good_next;
          locked_reg <= (good_next == GOOD_MAX);
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        good_next  = good_reg;
        err_next   = 1'b0;
        if (!run) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          good_next  = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              state_next = ST_SEEK;
              cnt_next   = '0;
            end
            ST_SEEK: begin
              if (edge_det[gi]) begin
                state_next = ST_TRACK;
                cnt_next   = CNT_W'(1);
              end
            end
            ST_TRACK: begin
              if (edge_det[gi]) begin
                cnt_next = CNT_W'(1);
                if (pass) begin
                  if (good_reg != GOOD_MAX) good_next = good_reg + 1'b1;
                end else begin
                  err_next  = 1'b1;
                  good_next = '0;
                end
              end else if (cnt_reg == lim) begin
                // Stuck level: report once, then wait for a fresh edge.
                err_next   = 1'b1;
                good_next  = '0;
                state_next = ST_SEEK;
                cnt_next   = '0;
              end else if (cnt_reg != '1) begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            default: begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              good_next  = '0;
            end
          endcase
        end
      end

      assign err_ev[gi]     = err_next;
      assign locked_vec[gi] = locked_reg;
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
      assign meas[gi] = cnt_reg;
`endif
    end
  endgenerate

  always_comb begin
    err_sum = {1'b0, err_cnt_reg};
    for (int i = 0; i < NUM_CH; i++) begin
      err_sum = err_sum + 17'(err_ev[i]);
    end
    err_cnt_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg    <= '0;
      err_ch_reg     <= '0;
      all_locked_reg <= 1'b0;
    end else begin
      all_locked_reg <= &locked_vec;
      if (clear_err) begin
        err_cnt_reg <= '0;
        err_ch_reg  <= '0;
      end else begin
        err_cnt_reg <= err_cnt_next;
        err_ch_reg  <= err_ch_reg | err_ev;
      end
    end
  end

  assign ch_locked  = locked_vec;
  assign all_locked = all_locked_reg;
  assign err_ch     = err_ch_reg;
  assign err_cnt    = err_cnt_reg;

`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cap_valid_reg;
  logic [CH_W-1:0]  cap_ch_reg, first_ch;
  logic [CNT_W-1:0] cap_meas_reg, first_meas;

  // Descending scan so the lowest failing index is the one that sticks.
  always_comb begin
    first_ch   = '0;
    first_meas = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_ev[i]) begin
        first_ch   = CH_W'(i);
        first_meas = meas[i];
      end
    end
  end

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_reg <= 1'b0;
      cap_ch_reg    <= '0;
      cap_meas_reg  <= '0;
    end else if (clear_err) begin
      cap_valid_reg <= 1'b0;
    end else if (!cap_valid_reg && (|err_ev)) begin
      cap_valid_reg <= 1'b1;
      cap_ch_reg    <= first_ch;
      cap_meas_reg  <= first_meas;
    end
  end

  assign cap_valid = cap_valid_reg;
  assign cap_ch    = cap_ch_reg;
  assign cap_meas  = cap_meas_reg;
`endif

endmodule

// File: tb/tb_ltpi_gpio_pattern_checker.sv
// Self-checking bench for ltpi_gpio_pattern_checker: table-driven ch0 sequence, hand-written corner
// cases and randomized single-channel episodes checked against a duration-based model.
module tb_ltpi_gpio_pattern_checker;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 24;
  localparam int EXP_HIGH = 100;
  localparam int EXP_LOW  = 20;
  localparam int TOL      = 2;
  localparam int LOCK_N   = 2;

  logic              clk_60m = 1'b0;
  logic              rst_n = 1'b0;
  logic              aligned = 1'b0;
  logic              nl_gpio_stable = 1'b0;
  logic [NUM_CH-1:0] mon_in = '0;
  logic              clear_err = 1'b0;
  logic [NUM_CH-1:0] ch_locked;
  logic              all_locked;
  logic [NUM_CH-1:0] err_ch;
  logic [15:0]       err_cnt;
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  logic              cap_valid;
  logic [1:0]        cap_ch;
  logic [CNT_W-1:0]  cap_meas;
`endif

  int checks = 0;
  int passes = 0;

  ltpi_gpio_pattern_checker #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH),
    .EXP_LOW(EXP_LOW), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .clk_60m(clk_60m),
    .rst_n(rst_n),
    .aligned(aligned),
    .nl_gpio_stable(nl_gpio_stable),
    .mon_in(mon_in),
    .clear_err(clear_err),
    .ch_locked(ch_locked),
    .all_locked(all_locked),
    .err_ch(err_ch),
    .err_cnt(err_cnt)
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
    ,
    .cap_valid(cap_valid),
    .cap_ch(cap_ch),
    .cap_meas(cap_meas)
`endif
  );

  always #8 clk_60m = ~clk_60m;

  initial begin
    #(16 * 200000);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic lvl;
    int   dur;
    int   exp_err;
    logic exp_lock;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_60m);
      #1;
    end
  endtask

  // Drive the masked channels to lvl and hold for dur clock cycles.
  task automatic seg(input logic [NUM_CH-1:0] mask, input logic lvl, input int dur);
    mon_in = lvl ? (mon_in | mask) : (mon_in & ~mask);
    tick(dur);
  endtask

  task automatic restart_run();
    aligned = 1'b0;
    mon_in  = '0;
    tick(5);
    aligned = 1'b1;
    tick(5);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  function automatic int exp_of(input logic lvl);
    return lvl ? EXP_HIGH : EXP_LOW;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    int m_err;
    logic [NUM_CH-1:0] m_err_ch;
    logic [15:0] first_nz;
    logic [15:0] last_cnt;
    int decreases;

    tbl[0]  = '{1'b1, 100, 0, 1'b0};
    tbl[1]  = '{1'b0,  20, 0, 1'b0};
    tbl[2]  = '{1'b1, 100, 0, 1'b1};
    tbl[3]  = '{1'b0,  20, 0, 1'b1};
    tbl[4]  = '{1'b1, 103, 0, 1'b1};
    tbl[5]  = '{1'b0,  20, 1, 1'b0};
    tbl[6]  = '{1'b1, 100, 1, 1'b0};
    tbl[7]  = '{1'b0,  20, 1, 1'b1};
    tbl[8]  = '{1'b1, 102, 1, 1'b1};
    tbl[9]  = '{1'b0,  20, 1, 1'b1};
    tbl[10] = '{1'b1,  98, 1, 1'b1};
    tbl[11] = '{1'b0,  19, 1, 1'b1};
    tbl[12] = '{1'b1,  97, 1, 1'b1};
    tbl[13] = '{1'b0,  23, 2, 1'b0};
    tbl[14] = '{1'b1, 100, 3, 1'b0};
    tbl[15] = '{1'b0,  17, 3, 1'b0};
    tbl[16] = '{1'b1, 100, 4, 1'b0};
    tbl[17] = '{1'b0,  20, 4, 1'b0};
    tbl[18] = '{1'b1, 100, 4, 1'b1};

    // Reset state
    tick(3);
    check("reset ch_locked", 32'(ch_locked), 32'd0);
    check("reset all_locked", 32'(all_locked), 32'd0);
    check("reset err_ch", 32'(err_ch), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
    check("reset cap_valid", 32'(cap_valid), 32'd0);
`endif
    rst_n = 1'b1;
    nl_gpio_stable = 1'b1;
    aligned = 1'b1;
    tick(5);

    // Table-driven toggle sequence on ch0; each row checks the result of the previous segment.
    for (int r = 0; r < 19; r++) begin
      seg(4'b0001, tbl[r].lvl, tbl[r].dur);
      $display("row %0d lvl=%0b dur=%0d err_cnt=%0d ch_locked=%b", r, tbl[r].lvl, tbl[r].dur, err_cnt, ch_locked);
      check($sformatf("row%0d err_cnt", r), 32'(err_cnt), 32'(tbl[r].exp_err));
      check($sformatf("row%0d err_ch0", r), 32'(err_ch[0]), 32'(tbl[r].exp_err != 0));
      check($sformatf("row%0d ch_locked0", r), 32'(ch_locked[0]), 32'(tbl[r].exp_lock));
    end

    // Link drop mid-TRACK: lock lost next cycle, errors retained, relock after LOCK_N good periods.
    aligned = 1'b0;
    tick(1);
    check("drop ch_locked0", 32'(ch_locked[0]), 32'd0);
    tick(10);
    check("drop err_cnt kept", 32'(err_cnt), 32'd4);
    aligned = 1'b1;
    tick(3);
    seg(4'b0001, 1'b0, 20);
    check("restore first edge unchecked", 32'(err_cnt), 32'd4);
    seg(4'b0001, 1'b1, 100);
    check("restore one good", 32'(ch_locked[0]), 32'd0);
    seg(4'b0001, 1'b0, 20);
    check("restore relocked", 32'(ch_locked[0]), 32'd1);
    nl_gpio_stable = 1'b0;
    tick(1);
    check("nl unstable unlock", 32'(ch_locked[0]), 32'd0);
    nl_gpio_stable = 1'b1;
    restart_run();

    // Stuck ch1: a single timeout error, then silence in SEEK.
    seg(4'b0010, 1'b1, 100);
    seg(4'b0010, 1'b0, 20);
    seg(4'b0010, 1'b1, 100);
    seg(4'b0010, 1'b0, 20);
    mon_in[1] = 1'b1;
    tick(105);
    check("stuck before timeout err_cnt", 32'(err_cnt), 32'd4);
    check("stuck before timeout lock", 32'(ch_locked[1]), 32'd1);
    tick(1);
    check("stuck timeout err_cnt", 32'(err_cnt), 32'd5);
    check("stuck timeout err_ch1", 32'(err_ch[1]), 32'd1);
    check("stuck timeout unlock", 32'(ch_locked[1]), 32'd0);
    tick(110);
    check("stuck no repeat", 32'(err_cnt), 32'd5);
    seg(4'b0010, 1'b0, 10);
    check("seek edge unchecked", 32'(err_cnt), 32'd5);
    // Low-level timeout lands on the same cycle as clear_err; the clear must win.
    tick(15);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("clear wins err_cnt", 32'(err_cnt), 32'd0);
    check("clear wins err_ch", 32'(err_ch), 32'd0);
    tick(2);
    check("clear wins later", 32'(err_cnt), 32'd0);

    // All channels lock, then ch0/ch2/ch3 fail on the same cycle.
    restart_run();
    seg(4'b1111, 1'b1, 100);
    seg(4'b1111, 1'b0, 20);
    seg(4'b1111, 1'b1, 100);
    check("multi ch_locked", 32'(ch_locked), 32'hF);
    check("multi all_locked", 32'(all_locked), 32'd1);
    seg(4'b1111, 1'b0, 20);
    seg(4'b1111, 1'b1, 100);
    seg(4'b0010, 1'b0, 3);
    mon_in = mon_in & ~4'b1101;
    first_nz = 16'd0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (first_nz == 16'd0) first_nz = err_cnt;
    end
    check("multi step size", 32'(first_nz), 32'd3);
    check("multi err_cnt", 32'(err_cnt), 32'd3);
    check("multi err_ch", 32'(err_ch), 32'hD);
    check("multi ch_locked after", 32'(ch_locked), 32'h2);
    check("multi all_locked after", 32'(all_locked), 32'd0);
`ifdef LTPI_GPIO_CHK_CAPTURE_EN
    check("cap lowest valid", 32'(cap_valid), 32'd1);
    check("cap lowest ch", 32'(cap_ch), 32'd0);
    check("cap lowest meas", 32'(cap_meas), 32'd103);

    pulse_clear();
    check("cap clear valid", 32'(cap_valid), 32'd0);
    check("cap clear err_cnt", 32'(err_cnt), 32'd0);
    restart_run();
    // A 110-cycle high exceeds the timeout, so the timeout value 103 is captured.
    mon_in[2] = 1'b1;
    tick(110);
    check("cap ch2 valid", 32'(cap_valid), 32'd1);
    check("cap ch2 ch", 32'(cap_ch), 32'd2);
    check("cap ch2 meas", 32'(cap_meas), 32'd103);
    seg(4'b0001, 1'b1, 97);
    seg(4'b0001, 1'b0, 8);
    check("cap later err counted", 32'(err_cnt), 32'd2);
    check("cap kept ch", 32'(cap_ch), 32'd2);
    check("cap kept meas", 32'(cap_meas), 32'd103);
    pulse_clear();
    check("cap clear2 valid", 32'(cap_valid), 32'd0);
    seg(4'b0001, 1'b1, 4);
    check("cap new valid", 32'(cap_valid), 32'd1);
    check("cap new ch", 32'(cap_ch), 32'd0);
    check("cap new meas", 32'(cap_meas), 32'd9);
`endif

    // Randomized single-channel episodes against a duration-level model.
    restart_run();
    pulse_clear();
    m_err = 0;
    m_err_ch = '0;
    for (int ep = 0; ep < 12; ep++) begin
      int ch, n, good, lim;
      logic tracking;
      int dur [12];
      logic lv [12];
      restart_run();
      ch = int'($urandom_range(0, NUM_CH - 1));
      n = int'($urandom_range(4, 11));
      for (int k = 0; k < n; k++) begin
        int e, kind;
        lv[k] = (k % 2 == 0);
        e = exp_of(lv[k]);
        kind = int'($urandom_range(0, 9));
        if (k == n - 1) dur[k] = 8;
        else if (kind < 6) dur[k] = e + int'($urandom_range(0, 2 * TOL)) - TOL;
        else if (kind < 8) dur[k] = e + ((kind == 6) ? 1 : -1) * (TOL + 1 + int'($urandom_range(0, 3)));
        else dur[k] = e + TOL + 2 + int'($urandom_range(0, 10));
      end
      tracking = 1'b0;
      good = 0;
      for (int k = 0; k < n; k++) begin
        if (tracking) begin
          if (absi(dur[k-1] - exp_of(lv[k-1])) <= TOL) good = (good < LOCK_N) ? good + 1 : LOCK_N;
          else begin
            m_err++;
            m_err_ch[ch] = 1'b1;
            good = 0;
          end
        end else begin
          tracking = 1'b1;
        end
        lim = exp_of(lv[k]) + TOL + 1;
        if (dur[k] > lim) begin
          m_err++;
          m_err_ch[ch] = 1'b1;
          good = 0;
          tracking = 1'b0;
        end
      end
      for (int k = 0; k < n; k++) seg(NUM_CH'(1) << ch, lv[k], dur[k]);
      $display("episode %0d ch=%0d segs=%0d model_err=%0d model_lock=%0d dut_err=%0d", ep, ch, n, m_err, good == LOCK_N, err_cnt);
      check($sformatf("ep%0d err_cnt", ep), 32'(err_cnt), 32'((m_err > 16'hFFFF) ? 16'hFFFF : m_err));
      check($sformatf("ep%0d err_ch", ep), 32'(err_ch), 32'(m_err_ch));
      check($sformatf("ep%0d ch_locked", ep), 32'(ch_locked), (good == LOCK_N) ? (32'd1 << ch) : 32'd0);
      check($sformatf("ep%0d all_locked", ep), 32'(all_locked), 32'd0);
    end

    // Saturation: every channel fails on every cycle until the counter pins at 16'hFFFF.
    restart_run();
    pulse_clear();
    decreases = 0;
    last_cnt = err_cnt;
    for (int c = 0; c < 16500; c++) begin
      mon_in = ~mon_in;
      tick(1);
      if (err_cnt < last_cnt) decreases++;
      last_cnt = err_cnt;
    end
    tick(5);
    check("sat no wrap", 32'(decreases), 32'd0);
    check("sat err_cnt", 32'(err_cnt), 32'hFFFF);
    check("sat err_ch", 32'(err_ch), 32'hF);
    $display("saturation run done err_cnt=0x%0h", err_cnt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
